// File: rtl/fetch_decode_buffer.sv
// Two-entry elastic FIFO between fetch and decode; pre-decodes imm8 and sign-extension select.
// Latency: one cycle from push to head; no combinational input-to-output path.
// Backpressure: in_ready drops when both entries are held, from registered state only (never out_ready).
module fetch_decode_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc_inc,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc_inc,
    output logic [7:0]  out_imm8,
    output logic        out_ext_sel,
    output logic [1:0]  count
);

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // Entry storage; only written on an accepted push, so it needs no reset.
    logic [15:0] instr_q [2];
    logic [15:0] pc_q    [2];
    logic [1:0]  ext_q;

    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;

    logic        push;
    logic        pop;
    logic        in_ext_sel;

    assign in_ready  = rst_n & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Select 8-bit sign extension for LBI, the conditional branches, JR and JALR.
    always_comb begin
        in_ext_sel = 1'b0;
        case (in_instr[15:11])
            5'b11000,
            5'b01100,
            5'b01101,
            5'b01110,
            5'b01111,
            5'b00101,
            5'b00111: in_ext_sel = 1'b1;
            default:  in_ext_sel = 1'b0;
        endcase
    end

    // Pointer and occupancy next-state; flush discards everything, including this cycle's push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous active-low reset; reset overrides flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the new entry at the tail; a flushed push is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_q[tail_q] <= in_instr;
            pc_q[tail_q]    <= in_pc_inc;
            ext_q[tail_q]   <= in_ext_sel;
        end
    end

    // Head presentation; NOP values whenever the buffer is empty.
    always_comb begin
        out_instr   = NOP_INSTR;
        out_pc_inc  = 16'h0000;
        out_ext_sel = 1'b0;
        if (out_valid) begin
            out_instr   = instr_q[head_q];
            out_pc_inc  = pc_q[head_q];
            out_ext_sel = ext_q[head_q];
        end
    end

    assign out_imm8 = out_instr[7:0];

endmodule

// File: doc/fetch_decode_buffer.md
# fetch_decode_buffer

Two-entry elastic buffer between the fetch stage and the decode stage of the 16-bit pipeline. It accepts fetched instructions and their PC+2 with a valid/ready handshake and presents them to decode in order. It also pre-extracts the low immediate byte and the immediate-width select that decode routes straight into the sign-extension unit. Flush support discards wrong-path instructions on a taken branch or jump.

## Interface
- No parameters; all widths fixed (16-bit instruction and PC, 8-bit immediate field).
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_instr  input  16  fetched instruction word.
- in_pc_inc  input  16  PC+2 of that instruction.
- in_ready  output  1  buffer can accept a push this cycle.
- flush  input  1  discard all held entries (branch/jump redirect).
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_instr  output  16  head instruction.
- out_pc_inc  output  16  head PC+2.
- out_imm8  output  8  head instr[7:0], driven to the sign-extension input.
- out_ext_sel  output  1  sign-extension select: 1 = 8-bit field (sign bit instr[7]), 0 = 5-bit field (sign bit instr[4]).
- count  output  2  occupancy, 0..2.

## Operation
- Storage: two entries {instr, pc_inc, ext_sel}, head/tail pointers or shift organisation (implementer's choice); behaviour visible only at ports.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = rst_n & (count != 2); depends on registered state only, never on out_ready.
- out_valid = (count != 0).
- ext_sel computed at push time from instr[15:11]: 1 for 11000 (LBI), 01100, 01101, 01110, 01111 (BEQZ/BNEZ/BLTZ/BGEZ), 00101 (JR), 00111 (JALR); 0 for all other opcodes (including SLBI, zero-extended elsewhere).
- Count update: push only +1; pop only -1; push & pop together: count unchanged, head advances, new entry written at tail.
- count=1 with push & pop: new entry becomes head on next cycle.
- count=0: pop impossible (out_valid=0); out_ready ignored.
- count=2: in_ready=0, in_valid ignored, no overwrite.
- Flush (priority over everything): next cycle count=0, out_valid=0; push and pop in the flush cycle are discarded/ignored; data outputs return to NOP values.
- When empty, out_instr=16'h0800 (NOP), out_pc_inc=16'h0000, out_imm8=8'h00, out_ext_sel=0.
- Order strictly FIFO; no reordering, no duplication.

## Timing
- Reset (rst_n=0 at rising edge): count=0, out_valid=0, out_instr=16'h0800, out_pc_inc=0, out_imm8=0, out_ext_sel=0; in_ready=0 while rst_n=0, 1 the first cycle after release.
- Reset mid-operation: all held entries discarded exactly as flush; reset overrides flush.
- Latency: instruction pushed at edge N is on out_* with out_valid=1 after edge N (cycle N+1); no combinational in->out path.
- Throughput: one push and one pop per cycle sustained when count=1.
- Outputs are registered or direct functions of registered state; out_imm8 = out_instr[7:0] always.

## Test plan
- Reset then idle: rst_n low 2 cycles -> out_instr=0x0800, out_valid=0, count=0, in_ready=0 during reset, 1 after release.
- Single pass: push 0xC0FF (LBI, pc_inc 0x0002) with out_ready=0 -> next cycle out_valid=1, out_instr=0xC0FF, out_imm8=0xFF, out_ext_sel=1, count=1; assert out_ready -> count=0.
- Fill and backpressure: push 0x4125 (ADDI) then 0x6003 (BEQZ), out_ready=0, keep in_valid=1 with 0x0800 -> count=2, in_ready=0, third word not stored; drain -> 0x4125 (ext_sel 0), then 0x6003 (ext_sel 1), in order.
- Streaming: count=1, push and pop every cycle for 8 words 0x1000..0x1007 -> count stays 1, outputs appear in order, one per cycle, none lost.
- Flush with simultaneous push/pop: count=2, assert flush, in_valid=1, out_ready=1 same cycle -> next cycle count=0, out_valid=0, out_instr=0x0800; flushed-cycle push not present.
- Mid-operation reset: count=2, drop rst_n for one cycle -> count=0, outputs at reset values, previous entries never reappear.
